// File: rtl/cordic_fp_pkg.sv
// Shared constants and packing helper for the CORDIC float<->fixed converters.
// Used by both fixed_to_float and float_to_fixed.
package cordic_fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_POS_ONE = 32'h3F80_0000;

    localparam int CORDIC_FRAC_BITS = 22;
    localparam int CORDIC_WIDTH     = 24;

    function automatic logic [31:0] fp_pack(
        input logic                sign,
        input logic [FP_EXP_W-1:0] exp_field,
        input logic [FP_MAN_W-1:0] man_field
    );
        fp_pack = {sign, exp_field, man_field};
    endfunction

endpackage

// File: rtl/cordic_lzc.sv
// Combinational leading-one locator: bit index of the highest set bit plus an
// all-zero flag, for a vector of any width >= 2.
module cordic_lzc #(
    parameter int WIDTH = 24,
    parameter int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        pos  = '0;
        zero = ~|vec;
        for (int i = 0; i < WIDTH; i++) begin
            pos = vec[i] ? POS_W'(i) : pos;
        end
    end

endmodule

// File: rtl/fixed_to_float.sv
// Signed fixed-point to IEEE-754 single converter, 3-stage valid/ready pipeline.
// Optional FIXED_TO_FLOAT_CLAMP_EN saturates |x| > 1.0 to +/-1.0 and flags it.
module fixed_to_float
    import cordic_fp_pkg::*;
#(
    parameter int IN_WIDTH  = CORDIC_WIDTH,
    parameter int FRAC_BITS = CORDIC_FRAC_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data
`ifdef FIXED_TO_FLOAT_CLAMP_EN
    ,
    output logic                out_clamped
`endif
);

    localparam int POS_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    logic                load1;
    logic                load2;
    logic                load3;

    logic                s1_valid;
    logic                s1_sign;
    logic [IN_WIDTH-1:0] s1_mag;
    logic                s2_valid;
    logic                s2_sign;
    logic [IN_WIDTH-1:0] s2_mag;
    logic [POS_W-1:0]    s2_pos;
    logic                s2_zero;

    logic [IN_WIDTH-1:0] abs_val;
    logic [IN_WIDTH-1:0] mag_next;
    logic [POS_W-1:0]    lzc_pos;
    logic                lzc_zero;
    logic [22:0]         man_next;
    logic [7:0]          exp_next;
    logic [31:0]         word_next;

`ifdef FIXED_TO_FLOAT_CLAMP_EN
    localparam logic [IN_WIDTH:0] ONE_FX = (IN_WIDTH + 1)'(1) << FRAC_BITS;
    logic clamp_hit;
    logic s1_clamp;
    logic s2_clamp;
`endif

    // Back-pressure chain: a stage refills when empty or when its successor drains it.
    always_comb begin
        load3    = ~out_valid | out_ready;
        load2    = ~s2_valid | load3;
        load1    = ~s1_valid | load2;
        in_ready = load1;
    end

    // S1 magnitude; the most-negative input wraps to exactly 2^(IN_WIDTH-1).
    always_comb begin
        if (in_data[IN_WIDTH-1]) begin
            abs_val = (~in_data) + IN_WIDTH'(1);
        end else begin
            abs_val = in_data;
        end
`ifdef FIXED_TO_FLOAT_CLAMP_EN
        clamp_hit = ({1'b0, abs_val} > ONE_FX);
        mag_next  = clamp_hit ? ONE_FX[IN_WIDTH-1:0] : abs_val;
`else
        mag_next  = abs_val;
`endif
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            s1_clamp <= 1'b0;
`endif
        end else if (load1) begin
            s1_valid <= in_valid;
            s1_sign  <= in_data[IN_WIDTH-1];
            s1_mag   <= mag_next;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            s1_clamp <= clamp_hit;
`endif
        end
    end

    cordic_lzc #(
        .WIDTH (IN_WIDTH),
        .POS_W (POS_W)
    ) u_lzc (
        .vec  (s1_mag),
        .pos  (lzc_pos),
        .zero (lzc_zero)
    );

    // Stage 2 register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_pos   <= '0;
            s2_zero  <= 1'b1;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            s2_clamp <= 1'b0;
`endif
        end else if (load2) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= s1_mag;
            s2_pos   <= lzc_pos;
            s2_zero  <= lzc_zero;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            s2_clamp <= s1_clamp;
`endif
        end
    end

    // S3 normalise: the leading one lands on the hidden bit (23) and is dropped.
    always_comb begin
        man_next = 23'(24'(s2_mag) << (5'd23 - 5'(s2_pos)));
        exp_next = 8'(s2_pos) + 8'(FP_BIAS) - 8'(FRAC_BITS);
        if (s2_zero) begin
            word_next = FP_ZERO;
        end else begin
            word_next = fp_pack(s2_sign, exp_next, man_next);
        end
    end

    // Stage 3 / output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= FP_ZERO;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            out_clamped <= 1'b0;
`endif
        end else if (load3) begin
            out_valid   <= s2_valid;
            out_data    <= word_next;
`ifdef FIXED_TO_FLOAT_CLAMP_EN
            out_clamped <= s2_clamp;
`endif
        end
    end

endmodule
